// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of WIDTH JK flip-flops.
//
// Takes one host command at a time over a valid/ready handshake and drives
// per-bit j/k/en into an external JK flop bank, reading the bank's q back
// for the count commands.
//
// Ports:
//   clk        system clock, shared with the flop bank
//   reset      asynchronous active-low reset
//   cmd_valid  host presents a command
//   cmd_ready  controller accepts a command this cycle (IDLE and out of reset)
//   cmd_op     0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 COUNT_UP,
//              6 COUNT_DOWN, 7 reserved (completes with err)
//   cmd_data   LOAD value or TOGGLE mask
//   cmd_steps  number of count cycles for opcodes 5 and 6
//   q_in       q feedback from the flop bank
//   j, k, en   per-bit drive into the bank
//   busy       high whenever the controller is not IDLE
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done for opcode 7

// Per-bit drive decode. Every bit sees the same op; only the data bit and
// the count enable differ between lanes.
module jk_bank_lane (
    input  logic       active,
    input  logic [2:0] op,
    input  logic       data_bit,
    input  logic       up_en,
    input  logic       dn_en,
    output logic       j,
    output logic       k,
    output logic       en
);
    always_comb begin
        j  = 1'b0;
        k  = 1'b0;
        en = 1'b0;
        if (active) begin
            case (op)
                3'd1: begin en = 1'b1;     k = 1'b1; end
                3'd2: begin en = 1'b1;     j = 1'b1; end
                3'd3: begin en = 1'b1;     j = data_bit; k = ~data_bit; end
                3'd4: begin en = data_bit; j = 1'b1;     k = 1'b1;      end
                3'd5: begin en = up_en;    j = 1'b1;     k = 1'b1;      end
                3'd6: begin en = dn_en;    j = 1'b1;     k = 1'b1;      end
                default: ;
            endcase
        end
    end
endmodule

module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] en,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COUNT, S_DONE} state_t;

    localparam logic [2:0] OP_RSV = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    steps_d = cmd_steps;
                    case (cmd_op)
                        3'd1, 3'd2, 3'd3, 3'd4: state_d = S_EXEC;
                        // A zero-step count completes without touching the bank.
                        3'd5, 3'd6: state_d = (cmd_steps != '0) ? S_COUNT : S_DONE;
                        default:    state_d = S_DONE;
                    endcase
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_COUNT: begin
                steps_d = steps_q - 1'b1;
                if (steps_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered from the next state so they line up
        // exactly with state_q.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_DONE) && (op_d == OP_RSV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Ready is gated by reset directly so the host never sees it during reset.
    assign cmd_ready = reset && (state_q == S_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    logic drive_active;
    assign drive_active = (state_q == S_EXEC) || (state_q == S_COUNT);

    // Bit i toggles on an up-count when all lower bits are 1, and on a
    // down-count when all lower bits are 0.
    logic [WIDTH-1:0] up_pre, dn_pre;
    assign up_pre[0] = 1'b1;
    assign dn_pre[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_pre
            assign up_pre[gi] = &q_in[gi-1:0];
            assign dn_pre[gi] = &(~q_in[gi-1:0]);
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            jk_bank_lane u_lane (
                .active   (drive_active),
                .op       (op_q),
                .data_bit (data_q[gi]),
                .up_en    (up_pre[gi]),
                .dn_en    (dn_pre[gi]),
                .j        (j[gi]),
                .k        (k[gi]),
                .en       (en[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_jk_bank_ctrl.sv
module tb_jk_bank_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_steps;
    logic [3:0] q_bank;
    logic [3:0] j, k, en;
    logic       busy, done, err;

    int passed = 0;
    int total  = 0;
    logic [3:0] mv;   // reference value of the bank

    always #5 clk = ~clk;

    jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
        .q_in(q_bank), .j(j), .k(k), .en(en),
        .busy(busy), .done(done), .err(err)
    );

    // The JK flop bank, reset by the shared system reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) q_bank <= 4'h0;
        else begin
            for (int b = 0; b < 4; b++) begin
                if (en[b]) begin
                    case ({j[b], k[b]})
                        2'b10: q_bank[b] <= 1'b1;
                        2'b01: q_bank[b] <= 1'b0;
                        2'b11: q_bank[b] <= ~q_bank[b];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Reference model: what each command does to the stored value.
    function automatic logic [3:0] nxt(input logic [2:0] op, input logic [3:0] d, input logic [3:0] v);
        case (op)
            3'd1: nxt = 4'h0;
            3'd2: nxt = 4'hF;
            3'd3: nxt = d;
            3'd4: nxt = v ^ d;
            3'd5: nxt = v + 4'd1;
            3'd6: nxt = v - 4'd1;
            default: nxt = v;
        endcase
    endfunction

    // Bits that must be enabled are exactly the bits that change (or the
    // whole bank for absolute writes).
    function automatic logic [3:0] exp_en(input logic [2:0] op, input logic [3:0] d, input logic [3:0] v);
        logic [3:0] up, dn;
        up = v + 4'd1;
        dn = v - 4'd1;
        case (op)
            3'd1, 3'd2, 3'd3: exp_en = 4'hF;
            3'd4: exp_en = d;
            3'd5: exp_en = v ^ up;
            3'd6: exp_en = v ^ dn;
            default: exp_en = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_j(input logic [2:0] op, input logic [3:0] d);
        case (op)
            3'd1: exp_j = 4'h0;
            3'd3: exp_j = d;
            3'd2, 3'd4, 3'd5, 3'd6: exp_j = 4'hF;
            default: exp_j = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_k(input logic [2:0] op, input logic [3:0] d);
        case (op)
            3'd2: exp_k = 4'h0;
            3'd3: exp_k = ~d;
            3'd1, 3'd4, 3'd5, 3'd6: exp_k = 4'hF;
            default: exp_k = 4'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from an IDLE negedge and follow it to completion,
    // checking every cycle. Junk is driven on the command bus while busy.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] steps);
        int ndrive;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_steps = steps;
        if (op >= 3'd1 && op <= 3'd4)                  ndrive = 1;
        else if ((op == 3'd5 || op == 3'd6) && steps != 0) ndrive = steps;
        else                                           ndrive = 0;
        @(negedge clk);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = 4'($urandom);
        cmd_steps = 8'($urandom_range(0, 5));
        for (int i = 0; i < ndrive; i++) begin
            chk("drive_busy", busy, 1);
            chk("drive_done", done, 0);
            chk("drive_ready", cmd_ready, 0);
            chk("drive_q", q_bank, mv);
            chk("drive_en", en, exp_en(op, d, mv));
            chk("drive_j", j, exp_j(op, d));
            chk("drive_k", k, exp_k(op, d));
            @(negedge clk);
            mv = nxt(op, d, mv);
        end
        chk("done_pulse", done, 1);
        chk("done_err", err, (op == 3'd7) ? 1 : 0);
        chk("done_busy", busy, 1);
        chk("done_en", en, 0);
        chk("done_q", q_bank, mv);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0; cmd_steps = 8'd0;
        mv = 4'h0;

        // 1: reset for two cycles
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // 2: LOAD then TOGGLE
        run_cmd(3'd3, 4'b1010, 8'd0);
        chk("load_val", q_bank, 4'b1010);
        run_cmd(3'd4, 4'b0110, 8'd0);
        chk("toggle_val", q_bank, 4'b1100);

        // 3: SET then COUNT_UP 3 (wraps through 0)
        run_cmd(3'd2, 4'h0, 8'd0);
        chk("set_val", q_bank, 4'hF);
        run_cmd(3'd5, 4'h0, 8'd3);
        chk("up3_val", q_bank, 4'b0010);

        // 4: CLEAR then COUNT_DOWN 2 (wraps through F)
        run_cmd(3'd1, 4'h0, 8'd0);
        chk("clear_val", q_bank, 4'h0);
        run_cmd(3'd6, 4'h0, 8'd2);
        chk("down2_val", q_bank, 4'b1110);

        // 5: zero-step count and reserved opcode
        run_cmd(3'd5, 4'h0, 8'd0);
        chk("up0_val", q_bank, 4'b1110);
        run_cmd(3'd7, 4'h5, 8'd3);
        chk("rsv_val", q_bank, 4'b1110);

        // 6: reset in the middle of COUNT_UP 10 after 4 steps from 0
        run_cmd(3'd1, 4'h0, 8'd0);
        chk("ready_mid", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'h0; cmd_steps = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_en", en, exp_en(3'd5, 4'h0, mv));
            chk("abort_q", q_bank, mv);
            @(negedge clk);
            mv = nxt(3'd5, 4'h0, mv);
        end
        chk("abort_before_rst", q_bank, 4'd4);
        chk("abort_busy", busy, 1);
        reset = 1'b0;
        #1;
        mv = 4'h0;
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_en", en, 0);
        chk("abort_rst_ready", cmd_ready, 0);
        chk("abort_rst_q", q_bank, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_done_after", done, 0);
        run_cmd(3'd3, 4'h5, 8'd0);
        chk("after_abort_load", q_bank, 4'h5);

        // Random commands against the model
        for (int n = 0; n < 40; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom_range(0, 20)));
            chk("rand_q", q_bank, mv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH JK flip-flops built from the team's existing JK flip-flop cell.
- Drives per-bit j, k and enable into the bank and reads the bank's q back.
- Executes one command at a time: clear, set, load, toggle-mask, and synchronous count up/down for N steps.
- Sits between a host command source (valid/ready handshake) and the flop bank.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank
CNT_W, 8, width of the step-count field for count commands

Ports:
clk  in  1  system clock; the bank's flops share this clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host presents a command
cmd_ready  out  1  controller accepts a command this cycle
cmd_op  in  3  opcode: 0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 COUNT_UP, 6 COUNT_DOWN, 7 reserved
cmd_data  in  WIDTH  LOAD value or TOGGLE mask
cmd_steps  in  CNT_W  number of count cycles for opcodes 5 and 6
q_in  in  WIDTH  q feedback from the flop bank
j  out  WIDTH  J inputs to the bank
k  out  WIDTH  K inputs to the bank
en  out  WIDTH  per-bit enable to the bank
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse, coincident with done, for opcode 7

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; op, data and remaining-step registers clear to 0.
  - j, k, en, busy, done and err are all 0.
  - cmd_ready is forced to 0 while reset=0.
  - The bank's flops are reset by the system reset; this block never drives them.
- FSM states: IDLE, EXEC, COUNT, DONE.
  - IDLE: cmd_ready=1. On an edge with cmd_valid=1, capture op, data and steps.
    - Opcodes 1–4 go to EXEC.
    - Opcodes 5–6 go to COUNT if steps is nonzero; otherwise go to DONE.
    - Opcodes 0 and 7 go directly to DONE.
  - EXEC: drive for exactly one cycle, then go to DONE.
  - COUNT: drive every cycle. Decrement the remaining-step count on each edge. When remaining==1 at an edge, go to DONE.
  - DONE: done=1 (and err=1 if the op was 7) for one cycle, then return to IDLE.
- Drive values are combinational from state, captured op/data and q_in. Outside EXEC and COUNT: j=k=en=0.
  - CLEAR: en=all ones, j=0, k=all ones.
  - SET: en=all ones, j=all ones, k=0.
  - LOAD: en=all ones, j=data, k=~data.
  - TOGGLE: en=data, j=k=all ones. Bits with a 0 in the mask hold.
  - COUNT_UP: j=k=all ones. en[0]=1; en[i]=&q_in[i-1:0].
  - COUNT_DOWN: j=k=all ones. en[0]=1; en[i]=&~q_in[i-1:0].
- Timing:
  - The bank updates on the same edge that ends a drive cycle.
  - Single-cycle op accepted at edge t: bank updated at edge t+1; done high in cycle t+1..t+2; cmd_ready high again after edge t+2.
  - COUNT with S steps: bank advances S times, at edges t+1..t+S; done follows in the next cycle.
- Arithmetic:
  - Counting is modulo 2^WIDTH.
  - Up from all ones wraps to 0 (every bit toggles).
  - Down from 0 wraps to all ones.
- Handshake:
  - Commands are ignored while busy=1, since cmd_ready=0.
  - cmd_valid may stay high across commands; a new command is taken on the first IDLE edge.
- Reset during EXEC or COUNT: the command is aborted with no done pulse, and the bank holds whatever value it had reached.

Test Plan:
1. Reset low for 2 cycles, then high -> j=k=en=0, busy=0, done=0, cmd_ready=0 during reset and 1 after release.
2. LOAD 4'b1010, then TOGGLE 4'b0110 -> q_in reads 1010 after the LOAD's EXEC edge and 1100 after the TOGGLE's EXEC edge; one done pulse per command.
3. SET, then COUNT_UP steps=3 -> q_in goes 1111, 0000, 0001, 0010; busy high for exactly 3 COUNT cycles plus 1 DONE cycle.
4. CLEAR, then COUNT_DOWN steps=2 -> q_in goes 0000, 1111, 1110; en=1111 on the first count cycle and 0001 on the second.
5. COUNT_UP steps=0, and opcode 7 -> each produces done within 2 cycles with q_in unchanged; err=1 only for opcode 7.
6. Reset asserted mid COUNT_UP steps=10 after 4 steps from 0 -> bank holds at 4 (with the shared system reset, flops read 0); no done pulse; the next command is accepted normally after release.
